// File: rtl/odesa_train_sequencer_if.sv
// rtl/odesa_train_sequencer_if.sv - ROM, event, label and score signals of the ODESA train sequencer
// master drives the sequencer inputs (bench/SoC); slave is the sequencer itself.
interface odesa_train_sequencer_if #(
  parameter int P_CH     = 20,
  parameter int P_CLS    = 3,
  parameter int P_VEC    = 150,
  parameter int P_EPOCHS = 8
);
  localparam int AW = (P_VEC > 1) ? $clog2(P_VEC) : 1;
  localparam int EW = $clog2(P_EPOCHS + 1);
  localparam int CW = $clog2(P_VEC + 1);

  logic              i_start;
  logic [P_CH-1:0]   i_event;
  logic [AW-1:0]     o_vec_addr;
  logic [P_CH-1:0]   i_vec_data;
  logic [P_CLS-1:0]  i_vec_label;
  logic [P_CLS-1:0]  i_spike_out;
  logic [P_CH-1:0]   o_event;
  logic [P_CLS-1:0]  o_label;
  logic              o_end_of_epochs;
  logic [EW-1:0]     o_epoch;
  logic [CW-1:0]     o_acc;
  logic              o_acc_valid;
  logic              o_busy;

  modport master (
    output i_start, i_event, i_vec_data, i_vec_label, i_spike_out,
    input  o_vec_addr, o_event, o_label, o_end_of_epochs, o_epoch, o_acc, o_acc_valid, o_busy
  );

  modport slave (
    input  i_start, i_event, i_vec_data, i_vec_label, i_spike_out,
    output o_vec_addr, o_event, o_label, o_end_of_epochs, o_epoch, o_acc, o_acc_valid, o_busy
  );
endinterface

// File: rtl/odesa_train_sequencer.sv
// rtl/odesa_train_sequencer.sv - ODESA epoch trainer: ROM replay, L2 spike scoring, then live pass-through
// Each vector takes P_WIN+3 cycles (FETCH, DRIVE, P_WIN x WAIT, NEXT); the first spike in the window decides.
module odesa_train_sequencer #(
  parameter int P_CH     = 20,
  parameter int P_CLS    = 3,
  parameter int P_VEC    = 150,
  parameter int P_EPOCHS = 8,
  parameter int P_WIN    = 16
) (
  input logic                    i_clk,
  input logic                    i_rst,
  odesa_train_sequencer_if.slave bus
);
  localparam int AW = (P_VEC > 1) ? $clog2(P_VEC) : 1;
  localparam int EW = $clog2(P_EPOCHS + 1);
  localparam int CW = $clog2(P_VEC + 1);
  localparam int WW = (P_WIN > 1) ? $clog2(P_WIN) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DRIVE, S_WAIT, S_NEXT, S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [EW-1:0]    epoch_q, epoch_d;
  logic [CW-1:0]    hits_q, hits_d;
  logic [CW-1:0]    acc_q, acc_d;
  logic [WW-1:0]    win_q, win_d;
  logic             decided_q, decided_d;
  logic             hit_q, hit_d;
  logic [P_CH-1:0]  event_q, event_d;
  logic [P_CLS-1:0] label_q, label_d;
  logic             acc_valid_q, acc_valid_d;
  logic             end_q, end_d;
  logic             busy_q, busy_d;
  logic [CW-1:0]    hits_inc;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    epoch_d     = epoch_q;
    hits_d      = hits_q;
    acc_d       = acc_q;
    win_d       = win_q;
    decided_d   = decided_q;
    hit_d       = hit_q;
    event_d     = '0;
    label_d     = label_q;
    acc_valid_d = 1'b0;
    end_d       = end_q;
    hits_inc    = hits_q + CW'(hit_q);

    case (state_q)
      S_IDLE: begin
        if (bus.i_start) begin
          state_d = S_FETCH;
          addr_d  = '0;
          epoch_d = '0;
          hits_d  = '0;
        end
      end
      S_FETCH: state_d = S_DRIVE;
      S_DRIVE: begin
        event_d   = bus.i_vec_data;
        label_d   = bus.i_vec_label;
        win_d     = '0;
        decided_d = 1'b0;
        hit_d     = 1'b0;
        state_d   = S_WAIT;
      end
      S_WAIT: begin
        // Only the first cycle with any spike scores the vector.
        if (!decided_q && (bus.i_spike_out != '0)) begin
          decided_d = 1'b1;
          hit_d     = (bus.i_spike_out == label_q);
        end
        if (win_q == WW'(P_WIN - 1)) begin
          state_d = S_NEXT;
        end else begin
          win_d = win_q + 1'b1;
        end
      end
      S_NEXT: begin
        if (addr_q == AW'(P_VEC - 1)) begin
          acc_d       = hits_inc;
          acc_valid_d = 1'b1;
          hits_d      = '0;
          addr_d      = '0;
          epoch_d     = epoch_q + 1'b1;
          if (epoch_q == EW'(P_EPOCHS - 1)) begin
            state_d = S_DONE;
            end_d   = 1'b1;
            label_d = '0;
          end else begin
            state_d = S_FETCH;
          end
        end else begin
          hits_d  = hits_inc;
          addr_d  = addr_q + 1'b1;
          state_d = S_FETCH;
        end
      end
      S_DONE: begin
        label_d = '0;
        if (bus.i_start) begin
          epoch_d = '0;
          hits_d  = '0;
          addr_d  = '0;
          end_d   = 1'b0;
          state_d = S_FETCH;
        end else begin
          event_d = bus.i_event;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_FETCH) || (state_d == S_DRIVE) ||
             (state_d == S_WAIT)  || (state_d == S_NEXT);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      epoch_q     <= '0;
      hits_q      <= '0;
      acc_q       <= '0;
      win_q       <= '0;
      decided_q   <= 1'b0;
      hit_q       <= 1'b0;
      event_q     <= '0;
      label_q     <= '0;
      acc_valid_q <= 1'b0;
      end_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      epoch_q     <= epoch_d;
      hits_q      <= hits_d;
      acc_q       <= acc_d;
      win_q       <= win_d;
      decided_q   <= decided_d;
      hit_q       <= hit_d;
      event_q     <= event_d;
      label_q     <= label_d;
      acc_valid_q <= acc_valid_d;
      end_q       <= end_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.o_vec_addr      = addr_q;
  assign bus.o_event         = event_q;
  assign bus.o_label         = label_q;
  assign bus.o_end_of_epochs = end_q;
  assign bus.o_epoch         = epoch_q;
  assign bus.o_acc           = acc_q;
  assign bus.o_acc_valid     = acc_valid_q;
  assign bus.o_busy          = busy_q;
endmodule

// File: tb/tb_odesa_train_sequencer.sv
// tb/tb_odesa_train_sequencer.sv - scoreboard bench for odesa_train_sequencer (4 ch, 3 cls, 4 vec, 2 epochs, win 5)
module tb_odesa_train_sequencer;
  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  odesa_train_sequencer_if #(.P_CH(4), .P_CLS(3), .P_VEC(4), .P_EPOCHS(2)) bus ();

  odesa_train_sequencer #(
    .P_CH(4), .P_CLS(3), .P_VEC(4), .P_EPOCHS(2), .P_WIN(5)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  logic [3:0] rom_d [4] = '{4'h3, 4'h5, 4'h9, 4'hC};
  logic [2:0] rom_l [4] = '{3'b001, 3'b010, 3'b100, 3'b001};

  always @(posedge clk) begin
    bus.i_vec_data  <= rom_d[bus.o_vec_addr];
    bus.i_vec_label <= rom_l[bus.o_vec_addr];
  end

  int nchecks = 0;
  int nerrors = 0;
  logic [6:0] exp_evt [$];
  logic [4:0] exp_acc [$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerrors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: every training event pulse and every accuracy pulse must match the next queued entry.
  always @(negedge clk) begin
    if (bus.o_event != 4'd0 && !bus.o_end_of_epochs) begin
      if (exp_evt.size() == 0) chk("evt_unexpected", {25'd0, bus.o_event, bus.o_label}, 32'd0);
      else chk("evt_label", {25'd0, bus.o_event, bus.o_label}, {25'd0, exp_evt.pop_front()});
    end
    if (bus.o_acc_valid) begin
      if (exp_acc.size() == 0) chk("acc_unexpected", {27'd0, bus.o_acc, bus.o_epoch}, 32'd0);
      else chk("acc_epoch", {27'd0, bus.o_acc, bus.o_epoch}, {27'd0, exp_acc.pop_front()});
    end
  end

  function automatic logic [23:0] sp1(input int c, input logic [2:0] v);
    sp1 = {21'd0, v} << (3 * c);
  endfunction

  // Cycle c of a vector: 0 FETCH, 1 DRIVE, 2..6 WAIT1..5, 7 NEXT. Called at the negedge inside cycle 0.
  task automatic run_vec(input int v, input logic [23:0] sp, input int inj, input int ncyc);
    exp_evt.push_back({rom_d[v], rom_l[v]});
    for (int c = 0; c < ncyc; c++) begin
      bus.i_spike_out = sp[c*3 +: 3];
      bus.i_start     = (c == inj);
      chk("vec_addr", 32'(bus.o_vec_addr), 32'(v));
      chk("busy", 32'(bus.o_busy), 32'd1);
      @(negedge clk);
    end
    bus.i_spike_out = 3'b000;
  endtask

  task automatic run_epoch(input logic [23:0] s0, s1, s2, s3, input logic [2:0] acc, input logic [1:0] ep);
    exp_acc.push_back({acc, ep});
    run_vec(0, s0, -1, 8);
    run_vec(1, s1, -1, 8);
    run_vec(2, s2, -1, 8);
    run_vec(3, s3, -1, 8);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_event"}, 32'(bus.o_event), 32'd0);
    chk({tag, "_label"}, 32'(bus.o_label), 32'd0);
    chk({tag, "_acc"}, 32'(bus.o_acc), 32'd0);
    chk({tag, "_acc_valid"}, 32'(bus.o_acc_valid), 32'd0);
    chk({tag, "_epoch"}, 32'(bus.o_epoch), 32'd0);
    chk({tag, "_busy"}, 32'(bus.o_busy), 32'd0);
    chk({tag, "_end"}, 32'(bus.o_end_of_epochs), 32'd0);
    chk({tag, "_addr"}, 32'(bus.o_vec_addr), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    bus.i_start = 1'b0;
    bus.i_event = 4'h0;
    bus.i_spike_out = 3'b000;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk_idle("reset");
    repeat (5) begin
      @(negedge clk);
      chk("idle_busy", 32'(bus.o_busy), 32'd0);
      chk("idle_event", 32'(bus.o_event), 32'd0);
    end

    bus.i_start = 1'b1;
    @(negedge clk);
    // Epoch 1: hit, miss (wrong class), hit at WAIT5, no spike -> 2
    run_epoch(sp1(4, 3'b001), sp1(3, 3'b100), sp1(6, 3'b100), 24'd0, 3'd2, 2'd1);
    // Epoch 2: wrong-first miss, WAIT5 hit, FETCH/DRIVE/NEXT spikes ignored, same-cycle-as-event hit -> 2
    run_epoch(sp1(3, 3'b010) | sp1(4, 3'b001), sp1(6, 3'b010),
              sp1(0, 3'b100) | sp1(1, 3'b100) | sp1(7, 3'b100), sp1(2, 3'b001), 3'd2, 2'd2);

    chk("done_end", 32'(bus.o_end_of_epochs), 32'd1);
    chk("done_epoch", 32'(bus.o_epoch), 32'd2);
    chk("done_acc", 32'(bus.o_acc), 32'd2);
    chk("done_label", 32'(bus.o_label), 32'd0);
    chk("done_busy", 32'(bus.o_busy), 32'd0);
    bus.i_event = 4'hA;
    @(negedge clk);
    chk("pass_A", 32'(bus.o_event), 32'hA);
    bus.i_event = 4'h5;
    @(negedge clk);
    chk("pass_5", 32'(bus.o_event), 32'h5);
    bus.i_event = 4'h0;
    bus.i_start = 1'b1;
    @(negedge clk);
    chk("restart_end", 32'(bus.o_end_of_epochs), 32'd0);
    chk("restart_acc_held", 32'(bus.o_acc), 32'd2);
    chk("restart_epoch", 32'(bus.o_epoch), 32'd0);
    chk("restart_event", 32'(bus.o_event), 32'd0);

    // After restart every vector hits at WAIT1 -> 4
    run_epoch(sp1(2, 3'b001), sp1(2, 3'b010), sp1(2, 3'b100), sp1(2, 3'b001), 3'd4, 2'd1);
    // i_start in WAIT2 must be ignored, then reset in WAIT4 of vector 1
    run_vec(0, 24'd0, 3, 8);
    run_vec(1, sp1(2, 3'b010), -1, 5);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_idle("midrst");
    repeat (10) begin
      @(negedge clk);
      chk("post_rst_busy", 32'(bus.o_busy), 32'd0);
      chk("post_rst_event", 32'(bus.o_event), 32'd0);
    end
    chk("evt_queue_left", 32'(exp_evt.size()), 32'd0);
    chk("acc_queue_left", 32'(exp_acc.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end
endmodule
